// File: rtl/rs_issue_sched_if.sv
// Issue-scheduler bundle: allocation/free/ready inputs from the RS, stall inputs
// and registered grants toward the functional units.
interface rs_issue_sched_if #(
  parameter int RS_SZ  = 5,
  parameter int NUM_FU = 3
);
  localparam int IDX_W = $clog2(RS_SZ);

  logic                    flush;
  logic                    alloc_en;
  logic [IDX_W-1:0]        alloc_idx;
  logic [1:0]              alloc_fu;
  logic [RS_SZ-1:0]        req_vec;
  logic                    free_en;
  logic [IDX_W-1:0]        free_idx;
  logic [NUM_FU-1:0]       fu_stall;
  logic [NUM_FU-1:0]       grant_en;
  logic [NUM_FU*IDX_W-1:0] grant_idx;
  logic                    mult_busy;

  modport master (
    output flush, alloc_en, alloc_idx, alloc_fu, req_vec, free_en, free_idx, fu_stall,
    input  grant_en, grant_idx, mult_busy
  );

  modport slave (
    input  flush, alloc_en, alloc_idx, alloc_fu, req_vec, free_en, free_idx, fu_stall,
    output grant_en, grant_idx, mult_busy
  );
endinterface

// File: rtl/rs_issue_sched.sv
// Per-FU issue scheduler with registered grants and non-pipelined multiplier spacing.
// RS_SCHED_AGE_PRIO_EN: oldest-first via age matrix; undefined: highest index wins.
module rs_issue_sched #(
  parameter int RS_SZ    = 5,
  parameter int NUM_FU   = 3,
  parameter int MULT_LAT = 4
) (
  input logic           clock,
  input logic           reset,
  rs_issue_sched_if.slave sif
);
  localparam int IDX_W = $clog2(RS_SZ);
  localparam int CNT_W = $clog2(MULT_LAT + 1);

  logic [RS_SZ-1:0]        valid_q;
  logic [RS_SZ-1:0]        issued_q;
  logic [1:0]              fu_of_q [RS_SZ];
  logic [CNT_W-1:0]        mult_cnt_q;
  logic [NUM_FU-1:0]       grant_en_q;
  logic [NUM_FU*IDX_W-1:0] grant_idx_q;

  logic [NUM_FU-1:0]       accept;
  logic [NUM_FU-1:0]       load_en;
  logic [NUM_FU-1:0]       sel_found;
  logic [IDX_W-1:0]        sel_idx [NUM_FU];
  logic [RS_SZ-1:0]        elig [NUM_FU];
  logic                    mult_block;
`ifdef RS_SCHED_AGE_PRIO_EN
  logic [RS_SZ-1:0]        older_q [RS_SZ];
  logic                    has_older;
`endif

  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      accept[f]  = grant_en_q[f] && !sif.fu_stall[f];
      load_en[f] = !(grant_en_q[f] && sif.fu_stall[f]);
    end
    // The accepting cycle itself must not pick a new MULT op, or spacing collapses.
    mult_block = (mult_cnt_q > CNT_W'(1)) || accept[1];
`ifdef RS_SCHED_AGE_PRIO_EN
    has_older = 1'b0;
`endif
    for (int f = 0; f < NUM_FU; f++) begin
      sel_found[f] = 1'b0;
      sel_idx[f]   = '0;
      for (int i = 0; i < RS_SZ; i++)
        elig[f][i] = valid_q[i] && !issued_q[i] && sif.req_vec[i] && (fu_of_q[i] == 2'(f));
`ifdef RS_SCHED_AGE_PRIO_EN
      for (int i = 0; i < RS_SZ; i++) begin
        has_older = 1'b0;
        for (int j = 0; j < RS_SZ; j++)
          if (elig[f][j] && older_q[j][i]) has_older = 1'b1;
        if (elig[f][i] && !has_older && !sel_found[f]) begin
          sel_found[f] = 1'b1;
          sel_idx[f]   = IDX_W'(i);
        end
      end
`else
      for (int i = 0; i < RS_SZ; i++)
        if (elig[f][i]) begin
          sel_found[f] = 1'b1;
          sel_idx[f]   = IDX_W'(i);
        end
`endif
      if (f == 1 && mult_block) begin
        sel_found[f] = 1'b0;
        sel_idx[f]   = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset || sif.flush) begin
      valid_q     <= '0;
      issued_q    <= '0;
      mult_cnt_q  <= '0;
      grant_en_q  <= '0;
      grant_idx_q <= '0;
      for (int i = 0; i < RS_SZ; i++) begin
        fu_of_q[i] <= '0;
`ifdef RS_SCHED_AGE_PRIO_EN
        older_q[i] <= '0;
`endif
      end
    end else begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (load_en[f]) begin
          grant_en_q[f]                   <= sel_found[f];
          grant_idx_q[f*IDX_W +: IDX_W]   <= sel_idx[f];
          if (sel_found[f]) issued_q[sel_idx[f]] <= 1'b1;
        end
      end
      if (accept[1])
        mult_cnt_q <= CNT_W'(MULT_LAT);
      else if (mult_cnt_q != '0)
        mult_cnt_q <= mult_cnt_q - CNT_W'(1);
      if (sif.free_en && (int'(sif.free_idx) < RS_SZ) && valid_q[sif.free_idx]) begin
        valid_q[sif.free_idx]  <= 1'b0;
        issued_q[sif.free_idx] <= 1'b0;
      end
      // Allocation is applied last so it wins over a same-index free or issue.
      if (sif.alloc_en && (int'(sif.alloc_idx) < RS_SZ)) begin
        valid_q[sif.alloc_idx]  <= 1'b1;
        issued_q[sif.alloc_idx] <= 1'b0;
        fu_of_q[sif.alloc_idx]  <= sif.alloc_fu;
`ifdef RS_SCHED_AGE_PRIO_EN
        older_q[sif.alloc_idx] <= '0;
        for (int i = 0; i < RS_SZ; i++)
          if (valid_q[i] && (i != int'(sif.alloc_idx))) older_q[i][sif.alloc_idx] <= 1'b1;
`endif
      end
    end
  end

  assign sif.grant_en  = grant_en_q;
  assign sif.grant_idx = grant_idx_q;
  assign sif.mult_busy = (mult_cnt_q != '0);
endmodule

// File: tb/tb_rs_issue_sched.sv
// Randomized and directed bench for rs_issue_sched against a timestamp-based model.
module tb_rs_issue_sched;
  localparam int RS_SZ = 5, NUM_FU = 3, MULT_LAT = 4, IDX_W = $clog2(RS_SZ);

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rs_issue_sched_if #(.RS_SZ(RS_SZ), .NUM_FU(NUM_FU)) sif();
  rs_issue_sched #(.RS_SZ(RS_SZ), .NUM_FU(NUM_FU), .MULT_LAT(MULT_LAT)) dut (
    .clock(clock), .reset(reset), .sif(sif)
  );

  int total = 0, bad = 0, cyc = 0;
  bit m_valid [RS_SZ];
  bit m_issued[RS_SZ];
  int m_fu    [RS_SZ];
  int m_stamp [RS_SZ];
  int stamp_ctr = 0;
  bit m_gen [NUM_FU];
  int m_gidx[NUM_FU];
  int last_acc = -1000;

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < RS_SZ; i++) begin
      m_valid[i] = 0; m_issued[i] = 0; m_fu[i] = 0; m_stamp[i] = 0;
    end
    for (int f = 0; f < NUM_FU; f++) begin m_gen[f] = 0; m_gidx[f] = 0; end
    last_acc = -1000;
  endtask

  // Oldest = smallest allocation stamp; without age priority the highest index wins.
  function automatic int pick(int f);
    int best = -1;
    for (int i = 0; i < RS_SZ; i++)
      if (m_valid[i] && !m_issued[i] && sif.req_vec[i] && m_fu[i] == f) begin
`ifdef RS_SCHED_AGE_PRIO_EN
        if (best < 0 || m_stamp[i] < m_stamp[best]) best = i;
`else
        best = i;
`endif
      end
    return best;
  endfunction

  task automatic model_edge();
    bit acc[NUM_FU];
    int sel;
    if (sif.flush) begin model_clear(); return; end
    for (int f = 0; f < NUM_FU; f++) acc[f] = m_gen[f] && !sif.fu_stall[f];
    for (int f = 0; f < NUM_FU; f++) begin
      if (!(m_gen[f] && sif.fu_stall[f])) begin
        sel = pick(f);
        if (f == 1 && (acc[1] || cyc < last_acc + MULT_LAT)) sel = -1;
        m_gen[f]  = (sel >= 0);
        m_gidx[f] = (sel >= 0) ? sel : 0;
        if (sel >= 0) m_issued[sel] = 1;
      end
    end
    if (acc[1]) last_acc = cyc;
    if (sif.free_en && m_valid[sif.free_idx]) begin
      m_valid[sif.free_idx] = 0; m_issued[sif.free_idx] = 0;
    end
    if (sif.alloc_en) begin
      m_valid[sif.alloc_idx]  = 1;
      m_issued[sif.alloc_idx] = 0;
      m_fu[sif.alloc_idx]     = int'(sif.alloc_fu);
      stamp_ctr++;
      m_stamp[sif.alloc_idx]  = stamp_ctr;
    end
  endtask

  task automatic compare();
    for (int f = 0; f < NUM_FU; f++) begin
      check($sformatf("grant_en%0d", f), int'(sif.grant_en[f]), int'(m_gen[f]));
      check($sformatf("grant_idx%0d", f), int'(sif.grant_idx[f*IDX_W +: IDX_W]), m_gidx[f]);
    end
    check("mult_busy", int'(sif.mult_busy),
          int'(cyc >= last_acc + 1 && cyc <= last_acc + MULT_LAT));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    cyc++;
    #1;
    compare();
    sif.flush = 0; sif.alloc_en = 0; sif.free_en = 0;
  endtask

  task automatic idle();
    sif.flush = 0; sif.alloc_en = 0; sif.alloc_idx = '0; sif.alloc_fu = '0;
    sif.req_vec = '0; sif.free_en = 0; sif.free_idx = '0; sif.fu_stall = '0;
  endtask

  task automatic alloc(int idx, int fu);
    sif.alloc_en = 1; sif.alloc_idx = IDX_W'(idx); sif.alloc_fu = 2'(fu);
    step();
  endtask

  task automatic free_e(int idx);
    sif.free_en = 1; sif.free_idx = IDX_W'(idx);
    step();
  endtask

  function automatic int gidx(int f);
    return int'(sif.grant_idx[f*IDX_W +: IDX_W]);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp0, exp1, k;
`ifdef RS_SCHED_AGE_PRIO_EN
    exp0 = 0; exp1 = 4;
`else
    exp0 = 4; exp1 = 0;
`endif
    model_clear();
    idle();
    reset = 1;
    #12;
    check("rst_grant_en", int'(sif.grant_en), 0);
    check("rst_mult_busy", int'(sif.mult_busy), 0);
    reset = 0;

    // ALU: idx 3 then idx 1, both ready
    alloc(3, 0);
    alloc(1, 0);
    sif.req_vec = 5'b01010;
    step();
    check("t1_en", int'(sif.grant_en[0]), 1);
    check("t1_idx_a", gidx(0), 3);
    step();
    check("t1_idx_b", gidx(0), 1);
    sif.req_vec = '0;
    free_e(3);
    free_e(1);

    // MULT spacing
    alloc(0, 1);
    alloc(4, 1);
    sif.req_vec = 5'b10001;
    step();
    check("t2_first_en", int'(sif.grant_en[1]), 1);
    check("t2_first_idx", gidx(1), exp0);
    for (int n = 0; n < MULT_LAT; n++) begin
      step();
      check("t2_gap_en", int'(sif.grant_en[1]), 0);
      check("t2_gap_busy", int'(sif.mult_busy), 1);
    end
    step();
    check("t2_second_en", int'(sif.grant_en[1]), 1);
    check("t2_second_idx", gidx(1), exp1);
    sif.req_vec = '0;
    free_e(0);
    free_e(4);

    // ALU stall hold
    alloc(2, 0);
    alloc(0, 0);
    sif.req_vec = 5'b00101;
    step();
    check("t3_idx", gidx(0), 2);
    sif.fu_stall = 3'b001;
    for (int n = 0; n < 3; n++) begin
      step();
      check("t3_hold_en", int'(sif.grant_en[0]), 1);
      check("t3_hold_idx", gidx(0), 2);
    end
    sif.fu_stall = '0;
    step();
    check("t3_next_idx", gidx(0), 0);
    sif.req_vec = '0;
    step();

    // same-index alloc and free
    free_e(0);
    alloc(4, 0);
    sif.free_en = 1; sif.free_idx = 3'd2;
    alloc(2, 0);
    sif.req_vec = 5'b10100;
    step();
    check("t4_first", gidx(0), 4);
    step();
    check("t4_realloc", gidx(0), 2);
    sif.req_vec = '0;
    free_e(4);
    free_e(2);
    for (int n = 0; n < MULT_LAT; n++) step();

    // flush with MULT counter mid-flight and a held ALU grant
    alloc(1, 1);
    alloc(3, 1);
    alloc(0, 0);
    sif.req_vec = 5'b01011;
    sif.fu_stall = 3'b001;
    step();
    step();
    step();
    check("t5_busy_pre", int'(sif.mult_busy), 1);
    sif.flush = 1;
    step();
    check("t5_flush_en", int'(sif.grant_en), 0);
    check("t5_flush_busy", int'(sif.mult_busy), 0);
    sif.req_vec = 5'b11111;
    sif.fu_stall = '0;
    for (int n = 0; n < 3; n++) begin
      step();
      check("t5_no_grant", int'(sif.grant_en), 0);
    end

    // asynchronous reset mid-cycle
    alloc(2, 1);
    alloc(4, 0);
    sif.req_vec = 5'b10100;
    sif.fu_stall = 3'b001;
    step();
    step();
    check("t6_pre_en0", int'(sif.grant_en[0]), 1);
    check("t6_pre_busy", int'(sif.mult_busy), 1);
    #2 reset = 1;
    #1;
    check("t6_async_en", int'(sif.grant_en), 0);
    check("t6_async_busy", int'(sif.mult_busy), 0);
    model_clear();
    idle();
    #3 reset = 0;

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      sif.flush = ($urandom_range(0, 149) == 0);
      sif.alloc_en = ($urandom_range(0, 2) == 0);
      k = $urandom_range(0, RS_SZ - 1);
      for (int t = 0; t < RS_SZ && m_valid[k] && $urandom_range(0, 9) != 0; t++)
        k = (k + 1) % RS_SZ;
      sif.alloc_idx = IDX_W'(k);
      sif.alloc_fu = 2'($urandom_range(0, 2));
      sif.free_en = ($urandom_range(0, 3) == 0);
      sif.free_idx = IDX_W'($urandom_range(0, RS_SZ - 1));
      sif.req_vec = RS_SZ'($urandom);
      for (int f = 0; f < NUM_FU; f++) sif.fu_stall[f] = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rs_issue_sched.md
Name: rs_issue_sched

Overview:
- Issue scheduler sitting between the reservation station and the functional units.
- Tracks relative age of occupied RS entries and picks, per FU class, the oldest ready entry each cycle.
- Drives registered per-FU grants.
- Enforces the non-pipelined multiplier occupancy and honours per-FU back-pressure.

Parameters:
RS_SZ, 5, number of reservation-station entries tracked
NUM_FU, 3, FU classes: 0 = ALU, 1 = MULT, 2 = MEM
MULT_LAT, 4, cycles the multiplier stays occupied after a grant is accepted
IDX_W, $clog2(RS_SZ), entry index width (derived, not overridden)

Ports:
clock  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous squash (interrupt/mispredict); clears all scheduler state
alloc_en  in  1  RS entry allocated this cycle
alloc_idx  in  IDX_W  index of allocated entry
alloc_fu  in  2  FU class of allocated entry
req_vec  in  RS_SZ  bit i = entry i has both operands ready
free_en  in  1  entry released after execute
free_idx  in  IDX_W  index of released entry
fu_stall  in  NUM_FU  bit f = FU f cannot accept this cycle
grant_en  out  NUM_FU  bit f = grant valid for FU f
grant_idx  out  NUM_FU*IDX_W  field f at [f*IDX_W +: IDX_W] = granted entry
mult_busy  out  1  multiplier occupancy counter non-zero

Behaviour:
- State:
  - valid[RS_SZ]
  - issued[RS_SZ]
  - fu_of[RS_SZ] (2 bits each)
  - age matrix older[i][j]: 1 = entry i older than j
  - mult_cnt (width $clog2(MULT_LAT+1))
  - registered grant_en/grant_idx
- Reset (async) and flush (sync) clear all state to 0:
  - grant_en = 0, grant_idx = 0, mult_busy = 0.
  - flush overrides every other input that cycle.
- Allocation: on alloc_en at posedge, entry k = alloc_idx:
  - valid[k] = 1, issued[k] = 0, fu_of[k] = alloc_fu.
  - Row older[k][*] = 0; column older[*][k] = 1 for all currently valid entries (new entry is youngest).
- Eligibility of entry i for FU f: valid[i] && !issued[i] && req_vec[i] && fu_of[i] == f.
  - An entry allocated this cycle is not eligible until the next cycle.
- Selection for FU f: the eligible entry i with no eligible same-class j where older[j][i].
- Grant latency: 1 cycle. The selection is registered into grant_en[f]/grant_idx[f]; issued[i] is set in the same edge, so an entry is never granted twice.
- Back-pressure: while fu_stall[f] = 1 and grant_en[f] = 1, grant_en[f]/grant_idx[f] hold unchanged and no new selection is made for f.
  - A grant is accepted on the cycle grant_en[f] && !fu_stall[f]; the register then loads the next selection (or 0).
- Multiplier:
  - On acceptance of a FU1 grant, mult_cnt loads MULT_LAT.
  - It decrements each cycle to 0.
  - No FU1 selection while mult_cnt > 1; a selection is allowed in the cycle mult_cnt == 1 so back-to-back spacing is exactly MULT_LAT.
- Free: on free_en, valid[free_idx] = 0 and issued[free_idx] = 0; the age column is left as-is (masked by valid).
- Simultaneous alloc_en and free_en:
  - Different indices: both apply.
  - Same index: allocation wins.
- Free of a non-valid entry: no effect.
- Alloc of an already-valid index: overwrites the entry and treats it as youngest (the upstream RS must not do this; no error is flagged).
- Full: all RS_SZ valid; selection unaffected. Empty: all grant_en = 0 after one cycle.

Optional Feature:
- Macro: RS_SCHED_AGE_PRIO_EN.
- Defined: oldest-first selection via the age matrix as above.
- Undefined: the age matrix is not built; selection is fixed priority, highest index wins. All other behaviour is identical.

Test Plan:
1. Alloc idx 3 (ALU) at cycle 0, then idx 1 (ALU) at cycle 1; assert req_vec = 5'b01010 at cycle 2 -> cycle 3: grant_en[0] = 1, grant_idx[0] = 3; cycle 4: grant_idx[0] = 1 (with RS_SCHED_AGE_PRIO_EN).
2. Alloc idx 0 and idx 4 as MULT, both ready -> first grant for idx 0, second grant exactly 4 cycles after first acceptance; mult_busy high for the 4 intervening cycles.
3. ALU grant idx 2 with fu_stall[0] = 1 for 3 cycles -> grant_en[0] = 1, grant_idx[0] = 2 held for 3 cycles; next entry granted the cycle after the stall drops.
4. Same cycle: alloc_en idx 2 and free_en idx 2 -> valid[2] = 1, issued[2] = 0, entry 2 is youngest.
5. Grants pending with mult_cnt = 3, pulse flush -> next cycle all grant_en = 0, mult_busy = 0, no grants until new allocations occur.
6. Assert reset asynchronously mid-cycle with active grants -> grant_en = 0 and mult_busy = 0 immediately, without waiting for a clock edge.
